// File: rtl/rtl_shift_out_595_pkg.sv
// rtl/rtl_shift_out_595_pkg.sv - shared FSM states, bit-count limit and bit-order helpers
// for the 74HC595 serialiser.
package rtl_shift_out_595_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCK_LO,
    ST_SCK_HI,
    ST_LATCH,
    ST_FINISH
  } state_e;

  localparam logic [2:0] BIT_CNT_MSB = 3'd7;

  function automatic logic pick_bit(input logic [7:0] sr, input logic msb_first);
    return msb_first ? sr[7] : sr[0];
  endfunction

  function automatic logic [7:0] advance(input logic [7:0] sr, input logic msb_first);
    return msb_first ? {sr[6:0], 1'b0} : {1'b0, sr[7:1]};
  endfunction

endpackage

// File: rtl/rtl_tick_div.sv
// rtl/rtl_tick_div.sv - CLK_DIV cycle divider; tick_o pulses on the last cycle of each period,
// and restart_i forces the count back to zero so every FSM state gets a full period.
module rtl_tick_div #(
  parameter int CLK_DIV = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic restart_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int W = $clog2(CLK_DIV + 1);
  localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (restart_i || !en_i || tick_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/rtl_shift_out_595.sv
// rtl/rtl_shift_out_595.sv - serialises a byte onto a 74HC595 chain (SCK/SDO/RCK) with a
// one-deep pending buffer; every output is registered from next-state values.
module rtl_shift_out_595
  import rtl_shift_out_595_pkg::*;
#(
  parameter int CLK_DIV   = 2,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] D,
  input  logic       LOAD,
  output logic       SCK,
  output logic       SDO,
  output logic       RCK,
  output logic       BUSY,
  output logic       DONE,
  output logic       OVR
);

  state_e     state_q, state_d;
  logic [7:0] sr_q, sr_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] pend_q, pend_d;
  logic       pend_v_q, pend_v_d;
  logic       ovr_q, ovr_d;
  logic       sck_q, sdo_q, rck_q, busy_q, done_q;
  logic       sck_d, sdo_d, rck_d, busy_d, done_d;
  logic       tick;
  logic       take_pend;
  logic       queue_load;

  rtl_tick_div #(.CLK_DIV(CLK_DIV)) u_tick_div (
    .CLK       (CLK),
    .RST       (RST),
    .restart_i (state_d != state_q),
    .en_i      (state_q != ST_IDLE),
    .tick_o    (tick)
  );

  // A byte left pending when FINISH fell back to IDLE is started from IDLE as well.
  assign queue_load = LOAD && ((state_q != ST_IDLE) || pend_v_q);

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    pend_v_d  = pend_v_q;
    ovr_d     = ovr_q;
    take_pend = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pend_v_q) begin
          sr_d      = pend_q;
          cnt_d     = '0;
          take_pend = 1'b1;
          state_d   = ST_SCK_LO;
        end else if (LOAD) begin
          sr_d    = D;
          cnt_d   = '0;
          state_d = ST_SCK_LO;
        end
      end
      ST_SCK_LO: begin
        if (tick) state_d = ST_SCK_HI;
      end
      ST_SCK_HI: begin
        if (tick) begin
          if (cnt_q == BIT_CNT_MSB) begin
            state_d = ST_LATCH;
          end else begin
            sr_d    = advance(sr_q, MSB_FIRST);
            cnt_d   = cnt_q + 3'd1;
            state_d = ST_SCK_LO;
          end
        end
      end
      ST_LATCH: begin
        if (tick) state_d = ST_FINISH;
      end
      ST_FINISH: begin
        if (pend_v_q) begin
          sr_d      = pend_q;
          cnt_d     = '0;
          take_pend = 1'b1;
          state_d   = ST_SCK_LO;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (take_pend) pend_v_d = 1'b0;
    if (queue_load) begin
      pend_d   = D;
      pend_v_d = 1'b1;
      if (pend_v_q && !take_pend) ovr_d = 1'b1;
    end

    sck_d  = (state_d == ST_SCK_HI);
    sdo_d  = ((state_d == ST_SCK_LO) || (state_d == ST_SCK_HI)) ? pick_bit(sr_d, MSB_FIRST) : 1'b0;
    rck_d  = (state_d == ST_LATCH);
    done_d = (state_d == ST_FINISH);
    busy_d = (state_d != ST_IDLE) || pend_v_d;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      sr_q     <= '0;
      cnt_q    <= '0;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
      ovr_q    <= 1'b0;
      sck_q    <= 1'b0;
      sdo_q    <= 1'b0;
      rck_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      ovr_q    <= ovr_d;
      sck_q    <= sck_d;
      sdo_q    <= sdo_d;
      rck_q    <= rck_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign SCK  = sck_q;
  assign SDO  = sdo_q;
  assign RCK  = rck_q;
  assign BUSY = busy_q;
  assign DONE = done_q;
  assign OVR  = ovr_q;

endmodule

// File: tb/tb_rtl_shift_out_595.sv
// tb/tb_rtl_shift_out_595.sv - directed self-checking bench: MSB-first and LSB-first instances,
// each observed through a 74HC595 model.
module tb_rtl_shift_out_595;

  logic       clk;
  logic       rst;
  logic [7:0] d_a, d_b;
  logic       load_a, load_b;
  logic       sck_a, sdo_a, rck_a, busy_a, done_a, ovr_a;
  logic       sck_b, sdo_b, rck_b, busy_b, done_b, ovr_b;

  int n_assert = 0;
  int n_fail   = 0;

  rtl_shift_out_595 #(.CLK_DIV(2), .MSB_FIRST(1'b1)) dut_a (
    .CLK(clk), .RST(rst), .D(d_a), .LOAD(load_a),
    .SCK(sck_a), .SDO(sdo_a), .RCK(rck_a), .BUSY(busy_a), .DONE(done_a), .OVR(ovr_a)
  );

  rtl_shift_out_595 #(.CLK_DIV(2), .MSB_FIRST(1'b0)) dut_b (
    .CLK(clk), .RST(rst), .D(d_b), .LOAD(load_b),
    .SCK(sck_b), .SDO(sdo_b), .RCK(rck_b), .BUSY(busy_b), .DONE(done_b), .OVR(ovr_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // 595 models: instance a expects its first bit at Q7, instance b at Q0.
  logic [7:0] sh_a, sh_b, out_a, out_b;
  int rises_a = 0;
  int rises_b = 0;

  always @(posedge sck_a or posedge rst) begin
    if (rst) sh_a <= 8'h00;
    else begin
      sh_a    <= {sh_a[6:0], sdo_a};
      rises_a <= rises_a + 1;
    end
  end

  always @(posedge sck_b or posedge rst) begin
    if (rst) sh_b <= 8'h00;
    else begin
      sh_b    <= {sdo_b, sh_b[7:1]};
      rises_b <= rises_b + 1;
    end
  end

  always @(posedge rck_a or posedge rst) begin
    if (rst) out_a <= 8'h00;
    else     out_a <= sh_a;
  end

  always @(posedge rck_b or posedge rst) begin
    if (rst) out_b <= 8'h00;
    else     out_b <= sh_b;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drives a one-cycle LOAD, then scrambles D; returns at the negedge after the accept edge.
  task automatic pulse(input bit sel, input logic [7:0] val);
    @(negedge clk);
    if (sel) begin d_b = val; load_b = 1'b1; end
    else     begin d_a = val; load_a = 1'b1; end
    @(negedge clk);
    if (sel) begin load_b = 1'b0; d_b = ~val; end
    else     begin load_a = 1'b0; d_a = ~val; end
  endtask

  // lat = cycles after the accept edge at which DONE is seen (-1 on timeout).
  task automatic xfer(input bit sel, input logic [7:0] val, output int lat, output int rck_n,
                      output logic busy0);
    pulse(sel, val);
    lat   = -1;
    rck_n = 0;
    busy0 = sel ? busy_b : busy_a;
    for (int m = 0; m < 200; m++) begin
      if (sel ? rck_b : rck_a) rck_n++;
      if (sel ? done_b : done_a) begin
        lat = m;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic monitor_a(output int n, output int gap, output int dt,
                           output logic [7:0] v0, output logic [7:0] v1);
    int when0;
    n = 0; gap = 0; dt = -1; v0 = 8'h00; v1 = 8'h00; when0 = 0;
    for (int c = 0; c < 300 && n < 2; c++) begin
      @(negedge clk);
      if (!busy_a) gap++;
      if (done_a) begin
        if (n == 0) begin v0 = out_a; when0 = c; end
        else        begin v1 = out_a; dt = c - when0; end
        n++;
      end
    end
  endtask

  int         lat, rck_n, r0, n, gap, dt;
  logic       busy0, found;
  logic [7:0] v0, v1;

  initial begin
    rst = 1'b1;
    d_a = 8'h00; d_b = 8'h00; load_a = 1'b0; load_b = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outs_a", {sck_a, sdo_a, rck_a, busy_a, done_a, ovr_a}, 6'b0);
    chk("reset_outs_b", {sck_b, sdo_b, rck_b, busy_b, done_b, ovr_b}, 6'b0);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_outs", {sck_a, sdo_a, rck_a, busy_a, done_a, ovr_a,
                        sck_b, sdo_b, rck_b, busy_b, done_b, ovr_b}, 12'b0);
    end

    // MSB first, 8'hA5: DONE 34 edges after the accept edge (cycle t0+35).
    r0 = rises_a;
    xfer(1'b0, 8'hA5, lat, rck_n, busy0);
    chk("a5_busy_next", busy0, 1);
    chk("a5_latency", lat, 34);
    chk("a5_rck_cycles", rck_n, 2);
    chk("a5_sck_rises", rises_a - r0, 8);
    chk("a5_bits", sh_a, 8'hA5);
    chk("a5_595", out_a, 8'hA5);
    chk("a5_rck_low_at_done", rck_a, 0);
    @(negedge clk);
    chk("a5_done_one_cycle", done_a, 0);
    chk("a5_busy_clear", busy_a, 0);

    // LSB first, 8'h01: first sampled bit 1, the rest 0.
    r0 = rises_b;
    xfer(1'b1, 8'h01, lat, rck_n, busy0);
    chk("lsb_latency", lat, 34);
    chk("lsb_sck_rises", rises_b - r0, 8);
    chk("lsb_595", out_b, 8'h01);
    chk("lsb_ovr", ovr_b, 0);

    // Queued byte: back-to-back transfers with BUSY held throughout.
    pulse(1'b0, 8'h3C);
    repeat (10) @(negedge clk);
    pulse(1'b0, 8'hC3);
    monitor_a(n, gap, dt, v0, v1);
    chk("q_done_count", n, 2);
    chk("q_first", v0, 8'h3C);
    chk("q_second", v1, 8'hC3);
    chk("q_busy_gap", gap, 0);
    chk("q_done_spacing", dt, 35);
    chk("q_ovr", ovr_a, 0);
    @(negedge clk);
    chk("q_busy_clear", busy_a, 0);

    // Overwrite: 8'h22 is replaced by 8'h33 and OVR latches.
    pulse(1'b0, 8'h11);
    repeat (5) @(negedge clk);
    pulse(1'b0, 8'h22);
    chk("ovr_before", ovr_a, 0);
    repeat (5) @(negedge clk);
    pulse(1'b0, 8'h33);
    chk("ovr_set", ovr_a, 1);
    monitor_a(n, gap, dt, v0, v1);
    chk("ovr_done_count", n, 2);
    chk("ovr_first", v0, 8'h11);
    chk("ovr_second", v1, 8'h33);
    chk("ovr_sticky", ovr_a, 1);

    // Reset during the 4th SCK high phase, then a clean transfer.
    r0 = rises_a;
    pulse(1'b0, 8'h5A);
    found = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (sck_a && (rises_a - r0 == 4)) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("rst_found_4th_high", found, 1);
    rst = 1'b1;
    #1;
    chk("rst_async_outs_a", {sck_a, sdo_a, rck_a, busy_a, done_a, ovr_a}, 6'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_idle_outs_a", {sck_a, sdo_a, rck_a, busy_a, done_a, ovr_a}, 6'b0);
    r0 = rises_a;
    xfer(1'b0, 8'hFF, lat, rck_n, busy0);
    chk("ff_latency", lat, 34);
    chk("ff_sck_rises", rises_a - r0, 8);
    chk("ff_595", out_a, 8'hFF);
    chk("ff_ovr", ovr_a, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
